// File: rtl/rv_pkg.sv
// Shared RV32I encoding definitions: format codes, base opcodes, field
// bit positions and an immediate-range helper.
package rv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned FUNCT7_LSB = 25;

    // True when imm[31:msb] are all equal, i.e. the value survives
    // truncation to msb+1 bits followed by sign extension.
    function automatic logic fits_signed(input logic [31:0] imm, input int unsigned msb);
        logic signed [31:0] hi;
        hi = $signed(imm) >>> msb;
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: decoded fields + full immediate -> RV32I word.
// legal_o drops for illegal formats and, when IMM_RANGE_CHECK_EN is
// defined, for immediates not representable in the selected format.
module instr_pack
    import rv_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    // Place each format's fields; bits a format does not define stay zero.
    always_comb begin
        word_o = '0;
        word_o[OPCODE_LSB +: 7] = opcode_i;
        legal_o = 1'b1;
        case (fmt_i)
            FMT_R: begin
                word_o[RD_LSB +: 5]     = rd_i;
                word_o[FUNCT3_LSB +: 3] = funct3_i;
                word_o[RS1_LSB +: 5]    = rs1_i;
                word_o[RS2_LSB +: 5]    = rs2_i;
                word_o[FUNCT7_LSB +: 7] = funct7_i;
            end
            FMT_I: begin
                word_o[RD_LSB +: 5]     = rd_i;
                word_o[FUNCT3_LSB +: 3] = funct3_i;
                word_o[RS1_LSB +: 5]    = rs1_i;
                word_o[31:20]           = imm_i[11:0];
            end
            FMT_S: begin
                word_o[FUNCT3_LSB +: 3] = funct3_i;
                word_o[RS1_LSB +: 5]    = rs1_i;
                word_o[RS2_LSB +: 5]    = rs2_i;
                word_o[31:25]           = imm_i[11:5];
                word_o[11:7]            = imm_i[4:0];
            end
            FMT_B: begin
                word_o[FUNCT3_LSB +: 3] = funct3_i;
                word_o[RS1_LSB +: 5]    = rs1_i;
                word_o[RS2_LSB +: 5]    = rs2_i;
                word_o[31]              = imm_i[12];
                word_o[30:25]           = imm_i[10:5];
                word_o[11:8]            = imm_i[4:1];
                word_o[7]               = imm_i[11];
            end
            FMT_U: begin
                word_o[RD_LSB +: 5]     = rd_i;
                word_o[31:12]           = imm_i[31:12];
            end
            FMT_J: begin
                word_o[RD_LSB +: 5]     = rd_i;
                word_o[31]              = imm_i[20];
                word_o[30:21]           = imm_i[10:1];
                word_o[20]              = imm_i[11];
                word_o[19:12]           = imm_i[19:12];
            end
            default: legal_o = 1'b0;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        case (fmt_i)
            FMT_I, FMT_S: if (!fits_signed(imm_i, 11)) legal_o = 1'b0;
            FMT_B:        if (!fits_signed(imm_i, 12) || imm_i[0]) legal_o = 1'b0;
            FMT_U:        if (imm_i[11:0] != '0) legal_o = 1'b0;
            FMT_J:        if (!fits_signed(imm_i, 20) || imm_i[0]) legal_o = 1'b0;
            default:      ;
        endcase
`endif
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs decoded instruction fields into RV32I words and
// streams them to the imem write port at auto-incrementing, wrapping
// addresses. Optional immediate range checking: IMM_RANGE_CHECK_EN.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       DEPTH_B   = 4096
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              enc_err,
    output logic [15:0]       word_cnt
);

    localparam logic [ADDR_W-1:0] END_ADDR = BASE_ADDR + ADDR_W'(DEPTH_B);

    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [31:0]       wr_data_q,  wr_data_d;
    logic              enc_err_q,  enc_err_d;
    logic [15:0]       word_cnt_q, word_cnt_d;

    logic [31:0]       pack_word;
    logic              pack_legal;
    logic              accept;
    logic              wr_done;
    logic [ADDR_W-1:0] addr_inc;

    instr_pack u_pack (
        .fmt_i    (in_fmt),
        .opcode_i (in_opcode),
        .rd_i     (in_rd),
        .rs1_i    (in_rs1),
        .rs2_i    (in_rs2),
        .funct3_i (in_funct3),
        .funct7_i (in_funct7),
        .imm_i    (in_imm),
        .word_o   (pack_word),
        .legal_o  (pack_legal)
    );

    assign in_ready = !restart && (!wr_valid_q || wr_ready);
    assign accept   = in_valid && in_ready;
    assign wr_done  = wr_valid_q && wr_ready;
    assign addr_inc = wr_addr_q + ADDR_W'(4);

    // Next state: completion advances address/count, acceptance reloads the
    // output register; both may happen together for full-rate streaming.
    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        enc_err_d  = enc_err_q;
        word_cnt_d = word_cnt_q;
        if (restart) begin
            wr_valid_d = 1'b0;
            wr_addr_d  = BASE_ADDR;
            enc_err_d  = 1'b0;
            word_cnt_d = '0;
        end else begin
            if (wr_done) begin
                wr_valid_d = 1'b0;
                wr_addr_d  = (addr_inc == END_ADDR) ? BASE_ADDR : addr_inc;
                if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 16'd1;
            end
            if (accept) begin
                if (pack_legal) begin
                    wr_valid_d = 1'b1;
                    wr_data_d  = pack_word;
                end else begin
                    enc_err_d  = 1'b1;
                end
            end
        end
    end

    // State registers; rst overrides restart and any handshake in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= '0;
            enc_err_q  <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            enc_err_q  <= enc_err_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign enc_err  = enc_err_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH_B=16 so wrap is reachable).
module tb_instr_encoder;
    import rv_pkg::*;

    localparam logic [31:0] BASE  = 32'h0;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, restart, in_valid, in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_addr, wr_data;
    logic        enc_err;
    logic [15:0] word_cnt;

    int checks   = 0;
    int failures = 0;

    logic [63:0] wlog[$];

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .DEPTH_B(DEPTH)) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .enc_err(enc_err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding straight from the RV32I format tables.
    function automatic logic [31:0] enc(input logic [2:0] f, input logic [6:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] imm,
                                        output bit ok);
        longint s;
        s  = longint'($signed(imm));
        ok = 1'b1;
        case (f)
            3'd0: enc = {f7, rs2, rs1, f3, rd, op};
            3'd1: begin
                enc = {imm[11:0], rs1, f3, rd, op};
`ifdef IMM_RANGE_CHECK_EN
                ok = (s >= -2048) && (s <= 2047);
`endif
            end
            3'd2: begin
                enc = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
`ifdef IMM_RANGE_CHECK_EN
                ok = (s >= -2048) && (s <= 2047);
`endif
            end
            3'd3: begin
                enc = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
`ifdef IMM_RANGE_CHECK_EN
                ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
`endif
            end
            3'd4: begin
                enc = {imm[31:12], rd, op};
`ifdef IMM_RANGE_CHECK_EN
                ok = (imm % 4096) == 0;
`endif
            end
            3'd5: begin
                enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
`ifdef IMM_RANGE_CHECK_EN
                ok = (s >= -(64'sd1 <<< 20)) && (s < (64'sd1 <<< 20)) && (s % 2 == 0);
`endif
            end
            default: begin
                enc = '0;
                ok  = 1'b0;
            end
        endcase
        if (s == 64'sd0) ok = ok;
    endfunction

    // Model state describes the registered outputs for the upcoming cycle.
    bit          mon_en = 1'b0;
    bit          m_pend = 1'b0;
    logic [31:0] m_addr = BASE;
    logic [31:0] m_data = '0;
    bit          m_err  = 1'b0;
    int unsigned m_cnt  = 0;

    // Compare DUT against the model, log completed writes, advance the model.
    always @(negedge clk) begin : monitor
        bit          ok, done, acc;
        logic [31:0] w;
        if (mon_en) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, !restart && (!m_pend || wr_ready)});
            chk("wr_valid", {31'b0, wr_valid}, {31'b0, m_pend});
            if (m_pend) begin
                chk("wr_addr", wr_addr, m_addr);
                chk("wr_data", wr_data, m_data);
            end
            chk("enc_err", {31'b0, enc_err}, {31'b0, m_err});
            chk("word_cnt", {16'b0, word_cnt}, m_cnt);
        end
        if (!rst && !restart && wr_valid && wr_ready)
            wlog.push_back({wr_addr, wr_data});
        if (rst) begin
            m_pend = 1'b0; m_addr = BASE; m_data = '0; m_err = 1'b0; m_cnt = 0;
            mon_en = 1'b1;
        end else if (restart) begin
            m_pend = 1'b0; m_addr = BASE; m_err = 1'b0; m_cnt = 0;
        end else begin
            done = m_pend && wr_ready;
            acc  = in_valid && (!m_pend || wr_ready);
            if (done) begin
                m_pend = 1'b0;
                m_addr = m_addr + 4;
                if (m_addr == BASE + DEPTH) m_addr = BASE;
                if (m_cnt < 65535) m_cnt++;
            end
            if (acc) begin
                w = enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, ok);
                if (ok) begin
                    m_pend = 1'b1;
                    m_data = w;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        int n;
        n = 0;
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        idle(1);
        restart = 1'b0;
    endtask

    task automatic chk_log(input string name, input int idx,
                           input logic [31:0] addr, input logic [31:0] data);
        logic [63:0] e;
        e = (idx < wlog.size()) ? wlog[idx] : 64'hxxxx_xxxx_xxxx_xxxx;
        chk({name, "_addr"}, e[63:32], addr);
        chk({name, "_data"}, e[31:0], data);
    endtask

    initial begin : stim
        int held;
        rst = 1'b1; restart = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        idle(3);
        rst = 1'b0;

        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
        chk("rst_wr_addr", wr_addr, BASE);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_enc_err", {31'b0, enc_err}, 32'd0);
        chk("rst_word_cnt", {16'b0, word_cnt}, 32'd0);

        // All six formats back-to-back; the fifth write wraps to BASE.
        wlog.delete();
        send(3'd1, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'h5);
        send(3'd2, OP_STORE,  5'd0, 5'd2, 5'd1, 3'd2, 7'd0,    32'd8);
        send(3'd3, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,    32'hFFFF_FFFC);
        send(3'd5, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd2048);
        send(3'd4, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0,    32'h1234_5000);
        send(3'd0, 7'h33,     5'd3, 5'd1, 5'd2, 3'd0, 7'h20,   32'h0);
        idle(3);
        chk("fmt_count", wlog.size(), 32'd6);
        chk_log("I",  0, 32'h0, 32'h0050_0093);
        chk_log("S",  1, 32'h4, 32'h0011_2423);
        chk_log("B",  2, 32'h8, 32'hFE20_8EE3);
        chk_log("J",  3, 32'hC, 32'h0010_00EF);
        chk_log("U",  4, 32'h0, 32'h1234_52B7);
        chk_log("R",  5, 32'h4, 32'h4020_81B3);
        chk("fmt_word_cnt", {16'b0, word_cnt}, 32'd6);

        pulse_restart();
        chk("restart_addr", wr_addr, BASE);
        chk("restart_cnt", {16'b0, word_cnt}, 32'd0);

        // Backpressure: first word held 5 cycles while the next bundle waits.
        wlog.delete();
        held = 0;
        wr_ready = 1'b0;
        fork
            begin
                send(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5);
                send(3'd1, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5);
                send(3'd1, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    if (wr_valid && !in_ready && wr_data == 32'h0050_0093 && wr_addr == BASE)
                        held++;
                end
                @(posedge clk);
                #1;
                wr_ready = 1'b1;
            end
        join
        chk("bp_held_cycles", held, 32'd4);
        idle(3);
        chk("bp_count", wlog.size(), 32'd3);
        chk_log("bp0", 0, 32'h0, 32'h0050_0093);
        chk_log("bp1", 1, 32'h4, 32'h0050_0113);
        chk_log("bp2", 2, 32'h8, 32'h0050_0193);
        chk("bp_word_cnt", {16'b0, word_cnt}, 32'd3);

        // Wrap after restart: 0,4,8,C,0.
        pulse_restart();
        wlog.delete();
        for (int i = 1; i <= 5; i++)
            send(3'd1, OP_IMM, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
        idle(3);
        chk("wrap_count", wlog.size(), 32'd5);
        chk_log("wrap0", 0, 32'h0, 32'h0010_0093);
        chk_log("wrap1", 1, 32'h4, 32'h0020_0113);
        chk_log("wrap2", 2, 32'h8, 32'h0030_0193);
        chk_log("wrap3", 3, 32'hC, 32'h0040_0213);
        chk_log("wrap4", 4, 32'h0, 32'h0050_0293);

        // Illegal format: consumed, no write, sticky error.
        wlog.delete();
        send(3'd7, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5);
        idle(2);
        chk("illegal_count", wlog.size(), 32'd0);
        chk("illegal_err", {31'b0, enc_err}, 32'd1);
        chk("illegal_cnt", {16'b0, word_cnt}, 32'd5);
        pulse_restart();
        chk("rs_err", {31'b0, enc_err}, 32'd0);
        chk("rs_addr", wr_addr, BASE);
        chk("rs_cnt", {16'b0, word_cnt}, 32'd0);

        // Out-of-range I immediate.
        wlog.delete();
        send(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        idle(2);
`ifdef IMM_RANGE_CHECK_EN
        chk("range_count", wlog.size(), 32'd0);
        chk("range_err", {31'b0, enc_err}, 32'd1);
`else
        chk("range_count", wlog.size(), 32'd1);
        chk_log("range", 0, 32'h0, 32'h8000_0093);
        chk("range_err", {31'b0, enc_err}, 32'd0);
`endif

        // Restart aborts a stalled write.
        pulse_restart();
        wlog.delete();
        wr_ready = 1'b0;
        send(3'd1, OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1);
        idle(1);
        pulse_restart();
        wr_ready = 1'b1;
        idle(2);
        chk("abort_valid", {31'b0, wr_valid}, 32'd0);
        chk("abort_count", wlog.size(), 32'd0);
        chk("abort_addr", wr_addr, BASE);

        // Illegal bundle accepted in the same cycle a legal word completes.
        send(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5);
        send(3'd6, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5);
        idle(2);
        chk("mix_count", wlog.size(), 32'd1);
        chk("mix_err", {31'b0, enc_err}, 32'd1);
        chk("mix_valid", {31'b0, wr_valid}, 32'd0);

        // Reset in the middle of a stalled write.
        wr_ready = 1'b0;
        send(3'd1, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        wr_ready = 1'b1;
        idle(1);
        chk("rstmid_valid", {31'b0, wr_valid}, 32'd0);
        chk("rstmid_addr", wr_addr, BASE);
        chk("rstmid_err", {31'b0, enc_err}, 32'd0);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
